fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001: Parameter ADDR_SIZE, default 4, is the FIFO address width; depth is 2^ADDR_SIZE words and pointers are ADDR_SIZE+1 bits.
REQ-002: Parameter AEMPTY_THRESH, default 2, is the almost-empty threshold in words; legal range 1 to 2^ADDR_SIZE-1.
REQ-003: Port rd_clk, input, 1 bit: read-domain clock; the block has one clock, and all state is on its rising edge.
REQ-004: Port rd_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005: Port rdq2_wptr, input, ADDR_SIZE+1 bits: Gray-coded write pointer, already two-flop synchronized into rd_clk.
REQ-006: Port rd_en, input, 1 bit: read request from the consumer.
REQ-007: Port clr_underflow, input, 1 bit: clears the sticky underflow flag.
REQ-008: Port rd_addr, output, ADDR_SIZE bits: binary read address to the dual-port RAM.
REQ-009: Port rd_ptr, output, ADDR_SIZE+1 bits: registered Gray read pointer, exported for synchronization into the write domain.
REQ-010: Port rd_empty, output, 1 bit: registered FIFO-empty flag.
REQ-011: Port rd_aempty, output, 1 bit: registered almost-empty flag.
REQ-012: Port rd_count, output, ADDR_SIZE+1 bits: registered count of readable words, range 0 to 2^ADDR_SIZE.
REQ-013: Port rd_underflow, output, 1 bit: sticky flag for a read attempted while empty.

Function
REQ-014: The block holds an internal binary read counter rbin of ADDR_SIZE+1 bits.
REQ-015: rd_inc = rd_en AND NOT rd_empty; only rd_inc advances any pointer.
REQ-016: rbin_next = rbin + rd_inc, modulo 2^(ADDR_SIZE+1); the MSB toggles on each wrap.
REQ-017: rgray_next = (rbin_next >> 1) XOR rbin_next.
REQ-018: rd_addr is driven combinationally as rbin[ADDR_SIZE-1:0]; the RAM read uses the current address, with no added latency.
REQ-019: Each cycle, rd_ptr <= rgray_next, so rd_ptr always equals the Gray code of rbin.
REQ-020: Each cycle, rd_empty <= (rgray_next == rdq2_wptr), compared over all ADDR_SIZE+1 bits.
REQ-021: wbin_sync is the combinational Gray-to-binary conversion of rdq2_wptr: bit i is the XOR of rdq2_wptr[ADDR_SIZE:i].
REQ-022: count_next = (wbin_sync - rbin_next) modulo 2^(ADDR_SIZE+1); each cycle, rd_count <= count_next.
REQ-023: Each cycle, rd_aempty <= (count_next <= AEMPTY_THRESH); rd_aempty is therefore 1 whenever rd_empty is 1.
REQ-024: Flag latency: a change on rdq2_wptr reaches rd_empty, rd_aempty and rd_count one rd_clk edge later.
REQ-025: Flag latency: a read via rd_inc is reflected in rd_ptr, rd_empty, rd_aempty and rd_count on the same edge that advances rbin.
REQ-026: If rd_en=1 while rd_empty=1, rd_underflow is set on that edge and rbin, rd_ptr and rd_addr hold.
REQ-027: rd_underflow is cleared by clr_underflow=1.
REQ-028: If a set and a clear of rd_underflow occur in the same cycle, the set wins.
REQ-029: Simultaneous read and write-pointer advance: the count uses both new values, so a read with one write arriving leaves rd_count unchanged.
REQ-030: Wrap-around: when rbin reaches all ones, the next read wraps it to 0; empty and count stay correct across the wrap through the MSB compare.
REQ-031: When the synchronized write pointer is a full depth ahead, rd_count = 2^ADDR_SIZE and rd_empty = 0.
REQ-032: No output glitches on rd_ptr: exactly one bit changes per increment.

Reset
REQ-033: While rd_rst=1, asynchronously: rbin=0, rd_ptr=0, rd_addr=0, rd_empty=1, rd_aempty=1, rd_count=0, rd_underflow=0.
REQ-034: Reset asserted mid-operation discards all read progress, with no partial update.
REQ-035: After rd_rst deasserts, the first rd_clk edge re-evaluates the flags from rdq2_wptr.
REQ-036: rd_en has no effect while rd_rst=1.

Verification
REQ-037: Reset with rdq2_wptr=0, then rd_en=1 for 3 cycles -> rd_empty=1, rd_addr=0 and rd_ptr=0 throughout; rd_underflow=1 after the first edge.
REQ-038: rdq2_wptr=Gray(5)=00111 with no reads -> one cycle later rd_count=5, rd_empty=0, rd_aempty=0; after 3 reads: rd_count=2, rd_aempty=1, rd_addr=3, rd_ptr=00010.
REQ-039: rdq2_wptr=Gray(16)=11000 from reset -> rd_count=16; 16 consecutive reads -> rd_addr sequence 0..15, then rd_empty=1, rd_ptr=11000, rbin=16.
REQ-040: Wrap: 32 writes and 32 reads interleaved one-for-one -> rd_count never exceeds 1, rbin wraps 31->0, rd_empty asserts after the final read, and rd_underflow stays 0.
REQ-041: Same-cycle set and clear: rd_empty=1, rd_en=1, clr_underflow=1 -> rd_underflow=1; a following cycle with clr_underflow=1 and rd_en=0 -> rd_underflow=0.
REQ-042: Reset mid-stream: rd_rst pulsed while rd_addr=7 -> all outputs take their REQ-033 values immediately, without waiting for an rd_clk edge.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer and flag control for an async FIFO.
// Keeps the read pointer, empty/almost-empty flags, count and underflow.
//
// Ports:
//   rd_clk        read-domain clock (rising edge)
//   rd_rst        async active-high reset
//   rdq2_wptr     Gray write pointer, already synced into rd_clk
//   rd_en         read request
//   clr_underflow clears the sticky underflow flag
//   rd_addr       binary RAM read address (combinational from rbin)
//   rd_ptr        registered Gray read pointer for the write domain
//   rd_empty      registered empty flag
//   rd_aempty     registered almost-empty flag
//   rd_count      registered readable-word count, 0..2^ADDR_SIZE
//   rd_underflow  sticky flag: read attempted while empty
module fifo_rd_ctrl #(
  parameter int ADDR_SIZE     = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic [ADDR_SIZE:0]   rdq2_wptr,
  input  logic                 rd_en,
  input  logic                 clr_underflow,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [ADDR_SIZE:0]   rd_ptr,
  output logic                 rd_empty,
  output logic                 rd_aempty,
  output logic [ADDR_SIZE:0]   rd_count,
  output logic                 rd_underflow
);

  localparam logic [ADDR_SIZE:0] AE_TH =
    (ADDR_SIZE+1)'(AEMPTY_THRESH);

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbin_next;
  logic [ADDR_SIZE:0] rgray_next;
  logic [ADDR_SIZE:0] wbin_sync;
  logic [ADDR_SIZE:0] count_next;
  logic               rd_inc;

  assign rd_inc     = rd_en & ~rd_empty;
  assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, rd_inc};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign rd_addr    = rbin[ADDR_SIZE-1:0];

  // Gray to binary: bit i is the XOR of all bits at or above i.
  always_comb begin
    wbin_sync = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      wbin_sync[i] = ^(rdq2_wptr >> i);
    end
  end

  // Extra MSB makes the modulo difference span 0..depth inclusive.
  assign count_next = wbin_sync - rbin_next;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rbin         <= '0;
      rd_ptr       <= '0;
      rd_empty     <= 1'b1;
      rd_aempty    <= 1'b1;
      rd_count     <= '0;
      rd_underflow <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rd_ptr    <= rgray_next;
      rd_empty  <= (rgray_next == rdq2_wptr);
      rd_aempty <= (count_next <= AE_TH);
      rd_count  <= count_next;
      // Set takes priority over a same-cycle clear.
      if (rd_en && rd_empty) begin
        rd_underflow <= 1'b1;
      end else if (clr_underflow) begin
        rd_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and random bench for fifo_rd_ctrl.
// Reference model tracks read/write word counts with plain arithmetic.
module tb_fifo_rd_ctrl;

  localparam int AS = 4;
  localparam int TH = 2;
  localparam int D  = 16;
  localparam int M  = 32;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic [AS:0]   rdq2_wptr = '0;
  logic          rd_en = 1'b0;
  logic          clr_underflow = 1'b0;
  logic [AS-1:0] rd_addr;
  logic [AS:0]   rd_ptr;
  logic          rd_empty;
  logic          rd_aempty;
  logic [AS:0]   rd_count;
  logic          rd_underflow;

  fifo_rd_ctrl #(
    .ADDR_SIZE(AS),
    .AEMPTY_THRESH(TH)
  ) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .rdq2_wptr(rdq2_wptr),
    .rd_en(rd_en),
    .clr_underflow(clr_underflow),
    .rd_addr(rd_addr),
    .rd_ptr(rd_ptr),
    .rd_empty(rd_empty),
    .rd_aempty(rd_aempty),
    .rd_count(rd_count),
    .rd_underflow(rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: words written / read, modulo 2*depth.
  int wb = 0;
  int rb = 0;
  int m_cnt = 0;
  bit m_uf = 1'b0;
  bit m_empty = 1'b1;
  bit m_aempty = 1'b1;
  bit chk_en = 1'b0;

  function automatic logic [AS:0] g(int b);
    logic [AS:0] v;
    v = (AS+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    rb = 0;
    m_uf = 1'b0;
    m_cnt = 0;
    m_empty = 1'b1;
    m_aempty = 1'b1;
  endtask

  // Model update for one rising edge, using pre-edge inputs.
  task automatic model_edge();
    if (rd_rst) begin
      model_reset();
    end else begin
      if (rd_en && m_empty) m_uf = 1'b1;
      else if (clr_underflow) m_uf = 1'b0;
      if (rd_en && !m_empty) rb = (rb + 1) % M;
      m_cnt = (wb - rb + M) % M;
      m_empty = (m_cnt == 0);
      m_aempty = (m_cnt <= TH);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    model_edge();
    #1;
  endtask

  task automatic set_w(int b);
    wb = b % M;
    rdq2_wptr = g(wb);
  endtask

  // Single compare process against the model.
  always @(negedge rd_clk) begin
    if (chk_en) begin
      check("addr", rd_addr, 32'(rb % D));
      check("ptr", rd_ptr, g(rb));
      check("empty", rd_empty, m_empty);
      check("aempty", rd_aempty, m_aempty);
      check("count", rd_count, m_cnt);
      check("underflow", rd_underflow, m_uf);
    end
  end

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rd_rst = 1'b1;
    rd_en = 1'b1;
    set_w(0);
    #1;
    model_reset();
    check("rst_addr", rd_addr, 0);
    check("rst_ptr", rd_ptr, 0);
    check("rst_empty", rd_empty, 1);
    check("rst_aempty", rd_aempty, 1);
    check("rst_count", rd_count, 0);
    check("rst_uf", rd_underflow, 0);
    tick();
    tick();
    rd_rst = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    chk_en = 1'b1;
    check("init_empty", rd_empty, 1);
    check("init_count", rd_count, 0);
    rd_rst = 1'b0;

    // Reads on an empty FIFO: pointer holds, underflow sets.
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("uf_set", rd_underflow, 1);
      check("uf_empty", rd_empty, 1);
      check("uf_addr", rd_addr, 0);
      check("uf_ptr", rd_ptr, 0);
    end
    rd_en = 1'b0;

    // Five words written, then three reads.
    set_w(5);
    tick();
    check("w5_count", rd_count, 5);
    check("w5_empty", rd_empty, 0);
    check("w5_aempty", rd_aempty, 0);
    rd_en = 1'b1;
    tick();
    tick();
    tick();
    rd_en = 1'b0;
    check("r3_count", rd_count, 2);
    check("r3_aempty", rd_aempty, 1);
    check("r3_addr", rd_addr, 3);
    check("r3_ptr", rd_ptr, 5'b00010);

    // Drain, then same-cycle set and clear of underflow.
    rd_en = 1'b1;
    tick();
    tick();
    check("drain_empty", rd_empty, 1);
    clr_underflow = 1'b1;
    tick();
    check("setclr_uf", rd_underflow, 1);
    check("setclr_addr", rd_addr, 5);
    rd_en = 1'b0;
    tick();
    check("clr_uf", rd_underflow, 0);
    clr_underflow = 1'b0;

    // Full depth ahead, then 16 reads.
    do_reset();
    set_w(16);
    tick();
    check("full_count", rd_count, 16);
    check("full_empty", rd_empty, 0);
    check("full_aempty", rd_aempty, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("seq_addr", rd_addr, i);
      tick();
    end
    rd_en = 1'b0;
    check("full_drain_empty", rd_empty, 1);
    check("full_drain_ptr", rd_ptr, 5'b11000);
    check("full_drain_count", rd_count, 0);

    // Reset mid-stream at address 7.
    do_reset();
    set_w(16);
    tick();
    rd_en = 1'b1;
    repeat (7) tick();
    rd_en = 1'b0;
    check("mid_addr", rd_addr, 7);
    do_reset();

    // One write, one read, 32 times: full wrap.
    for (int k = 0; k < 32; k++) begin
      set_w(wb + 1);
      rd_en = 1'b0;
      tick();
      check("wrap_cnt_w", rd_count <= 1, 1);
      rd_en = 1'b1;
      tick();
      check("wrap_cnt_r", rd_count <= 1, 1);
    end
    rd_en = 1'b0;
    check("wrap_empty", rd_empty, 1);
    check("wrap_uf", rd_underflow, 0);
    check("wrap_ptr", rd_ptr, 0);
    check("wrap_addr", rd_addr, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rd_en = ($urandom % 100) < 55;
      clr_underflow = ($urandom % 8) == 0;
      if (((wb - rb + M) % M) < D && ($urandom % 2) == 1)
        set_w(wb + 1);
      if (($urandom % 300) == 0)
        do_reset();
      else
        tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
